// File: rtl/sobel_pkg.sv
// Shared types for the Sobel pipeline: pixel and 3x3 window types plus the
// frame-tracking states used by the window generator.
package sobel_pkg;

  localparam int PIX_W    = 8;
  localparam int WIN_SIZE = 9;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef pixel_t window_t [0:WIN_SIZE-1];

  typedef enum logic [1:0] {
    FILL,
    STREAM,
    DONE
  } state_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// Single-line delay: the value read at a column is the one written there one
// full line (IMG_WIDTH accepts) earlier; the read happens before the write.
module sobel_line_buffer #(
  parameter int IMG_WIDTH = 640,
  parameter int PIX_W     = 8,
  parameter int COL_W     = $clog2(IMG_WIDTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [COL_W-1:0] addr,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  logic [PIX_W-1:0] mem [0:IMG_WIDTH-1];

  assign dout = mem[addr];

  // Storage is deliberately not reset; nothing downstream trusts it until a
  // full line has been written under the current frame.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= din;
    end
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Builds a 3x3 neighbourhood from a raster pixel stream using two line
// buffers and flags every window that lies fully inside the image.
module sobel_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = 8,
  parameter int COL_W      = $clog2(IMG_WIDTH),
  parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] pixel_in,
  input  logic             pixel_valid,
  input  logic             frame_start,
  output logic [PIX_W-1:0] windowBuffer [0:8],
  output logic             start_calculations,
  output logic [COL_W-1:0] center_col,
  output logic [ROW_W-1:0] center_row,
  output logic             frame_done,
  output logic             overrun
);

  import sobel_pkg::*;

  state_t           state, next_state;
  logic [COL_W-1:0] col, next_col, cur_col;
  logic [ROW_W-1:0] row, next_row, cur_row;
  logic             accept, win_valid, last_pix, drop, line_end;
  logic [PIX_W-1:0] lb0_out, lb1_out;

  // frame_start restarts the raster position within the same cycle, so a
  // coinciding pixel is treated as (0,0).
  assign cur_col   = frame_start ? '0 : col;
  assign cur_row   = frame_start ? '0 : row;
  assign accept    = !reset && pixel_valid && (frame_start || state != DONE);
  assign drop      = !reset && pixel_valid && !frame_start && state == DONE;
  assign line_end  = cur_col == COL_W'(IMG_WIDTH - 1);
  assign last_pix  = accept && line_end && cur_row == ROW_W'(IMG_HEIGHT - 1);
  assign win_valid = accept && cur_col >= COL_W'(2) && cur_row >= ROW_W'(2);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FILL;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= next_state;
      col   <= next_col;
      row   <= next_row;
    end
  end

  always_comb begin
    next_state = state;
    next_col   = col;
    next_row   = row;
    if (frame_start) begin
      next_state = FILL;
      next_col   = '0;
      next_row   = '0;
    end
    if (accept) begin
      if (last_pix) begin
        next_state = DONE;
        next_col   = '0;
        next_row   = '0;
      end else if (line_end) begin
        next_col   = '0;
        next_row   = cur_row + ROW_W'(1);
        next_state = (cur_row >= ROW_W'(1)) ? STREAM : FILL;
      end else begin
        next_col   = cur_col + COL_W'(1);
      end
    end
  end

  sobel_line_buffer #(
    .IMG_WIDTH(IMG_WIDTH),
    .PIX_W    (PIX_W),
    .COL_W    (COL_W)
  ) u_line0 (
    .clk  (clk),
    .wr_en(accept),
    .addr (cur_col),
    .din  (pixel_in),
    .dout (lb0_out)
  );

  sobel_line_buffer #(
    .IMG_WIDTH(IMG_WIDTH),
    .PIX_W    (PIX_W),
    .COL_W    (COL_W)
  ) u_line1 (
    .clk  (clk),
    .wr_en(accept),
    .addr (cur_col),
    .din  (lb0_out),
    .dout (lb1_out)
  );

  // Window shifts left and the new right column is (row-2, row-1, current).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 9; i++) begin
        windowBuffer[i] <= '0;
      end
      start_calculations <= 1'b0;
      frame_done         <= 1'b0;
      overrun            <= 1'b0;
      center_col         <= '0;
      center_row         <= '0;
    end else begin
      start_calculations <= win_valid;
      frame_done         <= last_pix;
      overrun            <= drop;
      if (accept) begin
        windowBuffer[0] <= windowBuffer[1];
        windowBuffer[1] <= windowBuffer[2];
        windowBuffer[2] <= lb1_out;
        windowBuffer[3] <= windowBuffer[4];
        windowBuffer[4] <= windowBuffer[5];
        windowBuffer[5] <= lb0_out;
        windowBuffer[6] <= windowBuffer[7];
        windowBuffer[7] <= windowBuffer[8];
        windowBuffer[8] <= pixel_in;
        center_col      <= cur_col - COL_W'(1);
        center_row      <= cur_row - ROW_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench for sobel_window_gen on a 4x4 image; a frame-level
// model predicts every window from the stored image.
module tb_sobel_window_gen;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pixel_valid = 1'b0;
  logic       frame_start = 1'b0;
  logic [7:0] pixel_in = 8'd0;
  logic [7:0] win [0:8];
  logic       start_calculations;
  logic [1:0] center_col;
  logic [1:0] center_row;
  logic       frame_done;
  logic       overrun;

  always #5 clk = ~clk;

  sobel_window_gen #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .PIX_W     (8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .pixel_in          (pixel_in),
    .pixel_valid       (pixel_valid),
    .frame_start       (frame_start),
    .windowBuffer      (win),
    .start_calculations(start_calculations),
    .center_col        (center_col),
    .center_row        (center_row),
    .frame_done        (frame_done),
    .overrun           (overrun)
  );

  int checks = 0;
  int errors = 0;
  bit check_en = 0;

  int img [0:H-1][0:W-1];
  int m_row = 0, m_col = 0;
  bit m_done = 0;
  int exp_win [0:8];
  bit exp_start = 0, exp_fdone = 0, exp_over = 0, win_known = 0;
  int exp_cc = 0, exp_cr = 0;
  int start_count = 0, accept_count = 0, first_start_acc = -1;
  int lit [9];

  task automatic cmp(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Drives one cycle of inputs and advances the image-level model.
  task automatic applyStimulus(input bit rst, input bit valid, input bit fs, input int pix);
    @(negedge clk);
    #1;
    reset       = rst;
    pixel_valid = valid;
    frame_start = fs;
    pixel_in    = pix[7:0];
    exp_start = 0;
    exp_fdone = 0;
    exp_over  = 0;
    if (rst) begin
      m_row = 0; m_col = 0; m_done = 0;
      for (int i = 0; i < 9; i++) exp_win[i] = 0;
      exp_cc = 0; exp_cr = 0; win_known = 1;
    end else begin
      if (fs) begin
        m_row = 0; m_col = 0; m_done = 0;
      end
      if (valid) begin
        if (m_done) begin
          exp_over = 1;
        end else begin
          img[m_row][m_col] = pix;
          accept_count++;
          if (m_row >= 2 && m_col >= 2) begin
            exp_start = 1;
            for (int r = 0; r < 3; r++)
              for (int c = 0; c < 3; c++)
                exp_win[3*r+c] = img[m_row-2+r][m_col-2+c];
            exp_cc = m_col - 1; exp_cr = m_row - 1; win_known = 1;
          end else begin
            win_known = 0;
          end
          if (m_row == H-1 && m_col == W-1) begin
            exp_fdone = 1; m_done = 1;
          end else if (m_col == W-1) begin
            m_col = 0; m_row++;
          end else begin
            m_col++;
          end
        end
      end
    end
  endtask

  task automatic checkOutput();
    cmp("start", int'(start_calculations), int'(exp_start));
    cmp("frame_done", int'(frame_done), int'(exp_fdone));
    cmp("overrun", int'(overrun), int'(exp_over));
    if (win_known) begin
      for (int i = 0; i < 9; i++) cmp($sformatf("win[%0d]", i), int'(win[i]), exp_win[i]);
      cmp("center_col", int'(center_col), exp_cc);
      cmp("center_row", int'(center_row), exp_cr);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput();
      if (start_calculations) begin
        start_count++;
        if (first_start_acc < 0) first_start_acc = accept_count;
      end
    end
  end

  // Hand-computed expectation checked just after the next rising edge.
  task automatic checkLit(input string name, input int vals[9], input int cc, input int cr, input int st);
    @(posedge clk);
    #2;
    for (int i = 0; i < 9; i++) cmp($sformatf("%s_win%0d", name, i), int'(win[i]), vals[i]);
    cmp({name, "_ccol"}, int'(center_col), cc);
    cmp({name, "_crow"}, int'(center_row), cr);
    cmp({name, "_start"}, int'(start_calculations), st);
  endtask

  task automatic feedPixel(input int i, input int off, input bit fs);
    applyStimulus(0, 1, fs, off + 16*(i / W) + (i % W));
  endtask

  initial begin
    applyStimulus(1, 0, 0, 0);
    check_en = 1;
    applyStimulus(1, 0, 0, 0);
    lit = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    checkLit("reset", lit, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    start_count = 0;
    for (int i = 0; i < 16; i++) begin
      feedPixel(i, 0, i == 0);
      if (i == 10) begin
        lit = '{0, 1, 2, 16, 17, 18, 32, 33, 34};
        checkLit("first", lit, 1, 1, 1);
        for (int s = 0; s < 3; s++) begin
          applyStimulus(0, 0, 0, 0);
          checkLit("stall", lit, 1, 1, 0);
        end
      end
      if (i == 11) begin
        lit = '{1, 2, 3, 17, 18, 19, 33, 34, 35};
        checkLit("after_stall", lit, 2, 1, 1);
      end
      if (i == 12 || i == 13) begin
        @(posedge clk);
        #2;
        cmp("wrap_gate", int'(start_calculations), 0);
      end
      if (i == 14) begin
        lit = '{16, 17, 18, 32, 33, 34, 48, 49, 50};
        checkLit("row3", lit, 1, 2, 1);
      end
      if (i == 15) begin
        @(posedge clk);
        #2;
        cmp("frame_done_lit", int'(frame_done), 1);
      end
    end
    applyStimulus(0, 0, 0, 0);
    cmp("start_count_f1", start_count, 4);

    applyStimulus(0, 1, 0, 99);
    lit = '{17, 18, 19, 33, 34, 35, 49, 50, 51};
    checkLit("overrun_hold", lit, 2, 2, 0);
    cmp("overrun_lit", int'(overrun), 1);
    applyStimulus(0, 0, 0, 0);

    for (int i = 0; i < 10; i++) feedPixel(i, 128, i == 0);

    accept_count = 0;
    first_start_acc = -1;
    start_count = 0;
    for (int i = 0; i < 16; i++) begin
      feedPixel(i, 64, i == 0);
      if (i == 10) begin
        lit = '{64, 65, 66, 80, 81, 82, 96, 97, 98};
        checkLit("restart", lit, 1, 1, 1);
      end
    end
    applyStimulus(0, 0, 0, 0);
    cmp("first_start_accepts", first_start_acc, 11);
    cmp("start_count_f3", start_count, 4);

    for (int i = 0; i < 11; i++) feedPixel(i, 0, i == 0);
    applyStimulus(1, 1, 0, 200);
    lit = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    checkLit("mid_reset", lit, 0, 0, 0);
    for (int i = 0; i < 3; i++) feedPixel(i, 32, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    #1;
    check_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
